// File: rtl/pipe_controller_if.sv
// Bus between pipe_controller and the datapath / hazard unit.
// The master drives the instruction, ALU flags and flush request;
// the slave (the controller) returns the stage controls and hazard status.
interface pipe_controller_if #(
  parameter int CONDW = 4,
  parameter int ALUCW = 4
);
  logic [19:0]      InstrD;
  logic [CONDW-1:0] ALUFlagsE;
  logic             FlushE;
  logic [1:0]       RegSrcD;
  logic [1:0]       ImmSrcD;
  logic             ALUSrcE;
  logic [ALUCW-1:0] ALUControlE;
  logic             BranchTakenE;
  logic             MemWriteM;
  logic             MemtoRegW;
  logic             PCSrcW;
  logic             RegWriteW;
  logic             RegWriteM;
  logic             MemtoRegE;
  logic             PCWrPendingF;

  modport master (
    output InstrD, ALUFlagsE, FlushE,
    input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM,
           MemtoRegW, PCSrcW, RegWriteW, RegWriteM, MemtoRegE, PCWrPendingF
  );

  modport slave (
    input  InstrD, ALUFlagsE, FlushE,
    output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM,
           MemtoRegW, PCSrcW, RegWriteW, RegWriteM, MemtoRegE, PCWrPendingF
  );
endinterface

// File: rtl/pipe_controller.sv
// Pipelined control unit for the 5-stage ARM-subset datapath.
// Decodes InstrD, carries controls through D/E, E/M and M/W registers,
// evaluates condition codes against the stored NZCV flags and gates the
// side effects of instructions whose condition fails.
module pipe_controller #(
  parameter int CONDW = 4,
  parameter int ALUCW = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_EOR = 4'b0001,
    CMD_SUB = 4'b0010,
    CMD_ADD = 4'b0100,
    CMD_CMP = 4'b1010,
    CMD_ORR = 4'b1100,
    CMD_MOV = 4'b1101
  } cmd_e;

  typedef enum logic [3:0] {
    C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011,
    C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
    C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
    C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
  } cond_e;

  // Instruction fields (InstrD holds Instr[31:12]).
  logic [3:0] cond_d;
  logic [1:0] op_d;
  logic [5:0] funct_d;
  logic [3:0] rd_d;
  logic       unused_rn;

  assign cond_d    = bus.InstrD[19:16];
  assign op_d      = bus.InstrD[15:14];
  assign funct_d   = bus.InstrD[13:8];
  assign rd_d      = bus.InstrD[3:0];
  assign unused_rn = ^bus.InstrD[7:4];

  // Decode-stage controls
  logic [1:0]       reg_src_d, imm_src_d, flag_w_d;
  logic             alu_src_d, reg_write_d, mem_write_d, memto_reg_d, branch_d;
  logic             pcs_d;
  logic [ALUCW-1:0] alu_ctl_d;

  // D/E register
  logic [1:0]       flag_w_e;
  logic             alu_src_e, reg_write_e, mem_write_e, memto_reg_e, branch_e, pcs_e;
  logic [ALUCW-1:0] alu_ctl_e;
  cond_e            cond_q;

  // E/M and M/W registers, flags
  logic             reg_write_m, mem_write_m, memto_reg_m, pcs_m;
  logic             reg_write_w, memto_reg_w, pcs_w;
  logic [CONDW-1:0] flags_q;

  logic             cond_ex;
  logic             pcs_e_gated;

  // Main decoder: op class, ALU command and flag-write mask from InstrD.
  always_comb begin
    reg_src_d   = 2'b00;
    imm_src_d   = 2'b00;
    flag_w_d    = 2'b00;
    alu_src_d   = 1'b0;
    reg_write_d = 1'b0;
    mem_write_d = 1'b0;
    memto_reg_d = 1'b0;
    branch_d    = 1'b0;
    alu_ctl_d   = '0;
    case (op_d)
      OP_DP: begin
        alu_src_d = funct_d[5];
        case (funct_d[4:1])
          CMD_AND: begin alu_ctl_d = ALUCW'(4'b0010); reg_write_d = 1'b1; flag_w_d = {funct_d[0], 1'b0}; end
          CMD_EOR: begin alu_ctl_d = ALUCW'(4'b0100); reg_write_d = 1'b1; flag_w_d = {funct_d[0], 1'b0}; end
          CMD_SUB: begin alu_ctl_d = ALUCW'(4'b0001); reg_write_d = 1'b1; flag_w_d = {2{funct_d[0]}}; end
          CMD_ADD: begin alu_ctl_d = ALUCW'(4'b0000); reg_write_d = 1'b1; flag_w_d = {2{funct_d[0]}}; end
          CMD_CMP: begin alu_ctl_d = ALUCW'(4'b0001); reg_write_d = 1'b0; flag_w_d = {2{funct_d[0]}}; end
          CMD_ORR: begin alu_ctl_d = ALUCW'(4'b0011); reg_write_d = 1'b1; flag_w_d = {funct_d[0], 1'b0}; end
          CMD_MOV: begin alu_ctl_d = ALUCW'(4'b0101); reg_write_d = 1'b1; flag_w_d = {funct_d[0], 1'b0}; end
          default: begin alu_ctl_d = '0; reg_write_d = 1'b0; flag_w_d = 2'b00; end
        endcase
      end
      OP_MEM: begin
        alu_src_d = 1'b1;
        imm_src_d = 2'b01;
        if (funct_d[0]) begin
          memto_reg_d = 1'b1;
          reg_write_d = 1'b1;
        end else begin
          mem_write_d = 1'b1;
          reg_src_d   = 2'b10;
        end
      end
      OP_BR: begin
        branch_d  = 1'b1;
        imm_src_d = 2'b10;
        reg_src_d = 2'b01;
        alu_src_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcs_d = reg_write_d & (rd_d == 4'hF);

  // Condition check in Execute against the stored N,Z,C,V flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond_q)
      C_EQ: cond_ex = flags_q[2];
      C_NE: cond_ex = ~flags_q[2];
      C_CS: cond_ex = flags_q[1];
      C_CC: cond_ex = ~flags_q[1];
      C_MI: cond_ex = flags_q[3];
      C_PL: cond_ex = ~flags_q[3];
      C_VS: cond_ex = flags_q[0];
      C_VC: cond_ex = ~flags_q[0];
      C_HI: cond_ex = flags_q[1] & ~flags_q[2];
      C_LS: cond_ex = ~flags_q[1] | flags_q[2];
      C_GE: cond_ex = (flags_q[3] == flags_q[0]);
      C_LT: cond_ex = (flags_q[3] != flags_q[0]);
      C_GT: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      C_LE: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      C_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign pcs_e_gated = pcs_e & cond_ex;

  // Pipeline registers and flags; FlushE bubbles only D/E, so the
  // instruction already in E still commits its flag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_w_e    <= 2'b00;
      alu_src_e   <= 1'b0;
      reg_write_e <= 1'b0;
      mem_write_e <= 1'b0;
      memto_reg_e <= 1'b0;
      branch_e    <= 1'b0;
      pcs_e       <= 1'b0;
      alu_ctl_e   <= '0;
      cond_q      <= C_EQ;
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      memto_reg_m <= 1'b0;
      pcs_m       <= 1'b0;
      reg_write_w <= 1'b0;
      memto_reg_w <= 1'b0;
      pcs_w       <= 1'b0;
      flags_q     <= '0;
    end else begin
      if (bus.FlushE) begin
        flag_w_e    <= 2'b00;
        alu_src_e   <= 1'b0;
        reg_write_e <= 1'b0;
        mem_write_e <= 1'b0;
        memto_reg_e <= 1'b0;
        branch_e    <= 1'b0;
        pcs_e       <= 1'b0;
        alu_ctl_e   <= '0;
        cond_q      <= C_EQ;
      end else begin
        flag_w_e    <= flag_w_d;
        alu_src_e   <= alu_src_d;
        reg_write_e <= reg_write_d;
        mem_write_e <= mem_write_d;
        memto_reg_e <= memto_reg_d;
        branch_e    <= branch_d;
        pcs_e       <= pcs_d;
        alu_ctl_e   <= alu_ctl_d;
        cond_q      <= cond_e'(cond_d);
      end
      reg_write_m <= reg_write_e & cond_ex;
      mem_write_m <= mem_write_e & cond_ex;
      memto_reg_m <= memto_reg_e;
      pcs_m       <= pcs_e_gated;
      reg_write_w <= reg_write_m;
      memto_reg_w <= memto_reg_m;
      pcs_w       <= pcs_m;
      if (flag_w_e[1] & cond_ex) flags_q[3:2] <= bus.ALUFlagsE[3:2];
      if (flag_w_e[0] & cond_ex) flags_q[1:0] <= bus.ALUFlagsE[1:0];
    end
  end

  assign bus.RegSrcD      = reg_src_d;
  assign bus.ImmSrcD      = imm_src_d;
  assign bus.ALUSrcE      = alu_src_e;
  assign bus.ALUControlE  = alu_ctl_e;
  assign bus.BranchTakenE = branch_e & cond_ex;
  assign bus.MemWriteM    = mem_write_m;
  assign bus.MemtoRegW    = memto_reg_w;
  assign bus.PCSrcW       = pcs_w;
  assign bus.RegWriteW    = reg_write_w;
  assign bus.RegWriteM    = reg_write_m;
  assign bus.MemtoRegE    = memto_reg_e;
  assign bus.PCWrPendingF = pcs_d | pcs_e_gated | pcs_m;

endmodule

// File: tb/tb_pipe_controller.sv
// Table-driven bench for pipe_controller plus hand sequences for flush,
// flag/flush interaction and mid-stream reset.
module tb_pipe_controller;

  localparam logic [19:0] BUB   = 20'h0C000; // op 11: undefined, no side effects
  localparam logic [19:0] ADD   = 20'hE2821; // ADD R1,R2,#5
  localparam logic [19:0] ADDEQ = 20'h02821; // ADDEQ R1,R2,#5
  localparam logic [19:0] SUBS  = 20'hE0500; // SUBS R0,R0,R0
  localparam logic [19:0] BEQ   = 20'h0A000; // BEQ
  localparam logic [19:0] LDR   = 20'hE5943; // LDR R3,[R4]
  localparam logic [19:0] STR   = 20'hE5843; // STR R3,[R4]
  localparam logic [19:0] MOVPC = 20'hE1A0F; // MOV PC,R1

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pipe_controller_if #(.CONDW(4), .ALUCW(4)) bus ();

  pipe_controller #(.CONDW(4), .ALUCW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  flags;
    logic        flush;
    logic [1:0]  regsrc;
    logic [1:0]  immsrc;
    logic        alusrc;
    logic [3:0]  aluctl;
    logic        bt, mw_m, mtr_w, pcs_w, rw_w, rw_m, mtr_e, pcp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [19:0] instr, logic [3:0] flags, logic flush,
                              logic [1:0] regsrc, logic [1:0] immsrc, logic alusrc,
                              logic [3:0] aluctl, logic bt, logic mw_m, logic mtr_w,
                              logic pcs_w, logic rw_w, logic rw_m, logic mtr_e, logic pcp);
    vec_t v;
    v.instr = instr; v.flags = flags; v.flush = flush;
    v.regsrc = regsrc; v.immsrc = immsrc; v.alusrc = alusrc; v.aluctl = aluctl;
    v.bt = bt; v.mw_m = mw_m; v.mtr_w = mtr_w; v.pcs_w = pcs_w;
    v.rw_w = rw_w; v.rw_m = rw_m; v.mtr_e = mtr_e; v.pcp = pcp;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(string tag, vec_t v);
    chk({tag, ".RegSrcD"},      int'(bus.RegSrcD),      int'(v.regsrc));
    chk({tag, ".ImmSrcD"},      int'(bus.ImmSrcD),      int'(v.immsrc));
    chk({tag, ".ALUSrcE"},      int'(bus.ALUSrcE),      int'(v.alusrc));
    chk({tag, ".ALUControlE"},  int'(bus.ALUControlE),  int'(v.aluctl));
    chk({tag, ".BranchTakenE"}, int'(bus.BranchTakenE), int'(v.bt));
    chk({tag, ".MemWriteM"},    int'(bus.MemWriteM),    int'(v.mw_m));
    chk({tag, ".MemtoRegW"},    int'(bus.MemtoRegW),    int'(v.mtr_w));
    chk({tag, ".PCSrcW"},       int'(bus.PCSrcW),       int'(v.pcs_w));
    chk({tag, ".RegWriteW"},    int'(bus.RegWriteW),    int'(v.rw_w));
    chk({tag, ".RegWriteM"},    int'(bus.RegWriteM),    int'(v.rw_m));
    chk({tag, ".MemtoRegE"},    int'(bus.MemtoRegE),    int'(v.mtr_e));
    chk({tag, ".PCWrPendingF"}, int'(bus.PCWrPendingF), int'(v.pcp));
  endtask

  task automatic drive(logic [19:0] instr, logic [3:0] flags, logic flush);
    bus.InstrD    = instr;
    bus.ALUFlagsE = flags;
    bus.FlushE    = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            instr  flags   fl rs  is  as ac    bt mw mtW pcW rwW rwM mtE pcp
    vecs.push_back(mk(ADD,   4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0)); // t0 reset state
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0)); // ADD in E
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0)); // ADD in M
    vecs.push_back(mk(SUBS,  4'h4, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0)); // ADD in W
    vecs.push_back(mk(BEQ,   4'h4, 0, 1, 2, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0)); // SUBS in E sets Z
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 1, 4'h0, 1, 0, 0, 0, 0, 1, 0, 0)); // BEQ taken
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0)); // BEQ M: no write
    vecs.push_back(mk(SUBS,  4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(BEQ,   4'h0, 0, 1, 2, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0)); // SUBS clears Z
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0)); // BEQ not taken
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(LDR,   4'h0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(STR,   4'h0, 0, 2, 1, 1, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0)); // LDR in E
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0)); // STR E, LDR M
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0)); // STR M, LDR W
    vecs.push_back(mk(MOVPC, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1)); // PCS in D
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h5, 0, 0, 0, 0, 0, 0, 0, 1)); // PCS in E
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 1)); // PCS in M
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 1, 0, 0, 0)); // PCSrcW
    vecs.push_back(mk(ADD,   4'h0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0)); // flushed
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(BUB,   4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0)); // no RegWriteW

    reset = 1'b1;
    drive(BUB, 4'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].flags, vecs[i].flush);
      @(negedge clk);
      chk_vec($sformatf("v%0d", i), vecs[i]);
      tick();
    end

    // Flush coincident with SUBS in E: SUBS still writes Z, BEQ is squashed.
    drive(SUBS, 4'h0, 1'b0); tick();
    drive(BEQ, 4'h4, 1'b1); tick();
    drive(BEQ, 4'h0, 1'b0);
    @(negedge clk);
    chk("flushE_bubble.ALUSrcE", int'(bus.ALUSrcE), 0);
    chk("flushE_bubble.BranchTakenE", int'(bus.BranchTakenE), 0);
    tick();
    drive(BUB, 4'h0, 1'b0);
    @(negedge clk);
    chk("flush_keeps_E_flags.BranchTakenE", int'(bus.BranchTakenE), 1);
    tick();

    // A flushed SUBS must leave Z=1 intact.
    drive(SUBS, 4'h0, 1'b1); tick();
    drive(BEQ, 4'h0, 1'b0); tick();
    drive(BUB, 4'h0, 1'b0);
    @(negedge clk);
    chk("flushed_subs_no_flags.BranchTakenE", int'(bus.BranchTakenE), 1);
    tick();

    // Reset with three instructions in flight, Z=1 beforehand.
    drive(ADD, 4'h0, 1'b0); tick();
    drive(LDR, 4'h0, 1'b0); tick();
    drive(MOVPC, 4'h0, 1'b0); tick();
    drive(BUB, 4'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("pre_reset.RegWriteW", int'(bus.RegWriteW), 1);
    chk("pre_reset.RegWriteM", int'(bus.RegWriteM), 1);
    chk("pre_reset.ALUControlE", int'(bus.ALUControlE), 5);
    tick();
    reset = 1'b0;
    drive(ADDEQ, 4'h0, 1'b0);
    @(negedge clk);
    chk_vec("post_reset", mk(ADDEQ, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive(BUB, 4'h0, 1'b0);
    @(negedge clk);
    chk("addeq_E.ALUSrcE", int'(bus.ALUSrcE), 1);
    tick();
    @(negedge clk);
    chk("addeq_notaken.RegWriteM", int'(bus.RegWriteM), 0);
    tick();
    @(negedge clk);
    chk("addeq_notaken.RegWriteW", int'(bus.RegWriteW), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
